// File: rtl/fifo_reader.sv
// Pops a latency-RD_LATENCY FIFO into a small circular skid buffer and streams
// the words downstream with valid/ready; pops are throttled so the buffer never overflows.
module fifo_reader #(
  parameter int DATA_WIDTH = 10,
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  empty_fifo,
  input  logic                  almost_empty_fifo,
  input  logic                  error_fifo,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            state,
  output logic [1:0]            in_flight,
  output logic [15:0]           words_read,
  output logic                  error_out
);

  // state  | meaning
  // IDLE   | no activity, waiting for enable
  // STREAM | issuing pops while buffer space and FIFO data allow
  // DRAIN  | enable dropped; finish in-flight reads and empty the buffer
  // ERROR  | FIFO error or lost capture; only reset leaves

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DRAIN  = 2'b10,
    ERROR  = 2'b11
  } state_t;

  state_t                st, st_next;
  logic [DATA_WIDTH-1:0] buf_mem [SKID_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         occ, occ_next;
  logic [RD_LATENCY-1:0] pop_sr;
  logic [1:0]            in_flight_next;
  logic                  blocked, blocked_next, pop_next;
  logic                  capture_due, retire, capture, transfer;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign capture_due = pop_sr[RD_LATENCY-1];
  assign retire      = capture_due && (in_flight != 2'd0);
  assign capture     = retire && (st != ERROR);
  assign out_valid   = (occ != '0);
  assign transfer    = out_valid && out_ready;
  assign out_data    = out_valid ? buf_mem[rd_ptr] : '0;
  assign error_out   = (st == ERROR);
  assign state       = st;

  always_comb begin
    st_next = st;
    if (error_fifo || (capture_due && in_flight == 2'd0)) begin
      st_next = ERROR;
    end else begin
      case (st)
        IDLE:    if (enable) st_next = STREAM;
        STREAM:  if (!enable) st_next = DRAIN;
        DRAIN: begin
          if (enable) st_next = STREAM;
          else if (in_flight == 2'd0 && occ == '0) st_next = IDLE;
        end
        default: st_next = ERROR;
      endcase
    end

    in_flight_next = in_flight;
    if (pop && !retire) in_flight_next = in_flight + 2'd1;
    else if (!pop && retire) in_flight_next = in_flight - 2'd1;

    occ_next = occ;
    if (capture && !transfer) occ_next = occ + 1'b1;
    else if (!capture && transfer) occ_next = occ - 1'b1;

    // A pop issued on the last FIFO word is not yet visible in empty_fifo,
    // so further pops wait until every outstanding read has landed.
    blocked_next = blocked;
    if (pop && almost_empty_fifo) blocked_next = 1'b1;
    else if (in_flight_next == 2'd0) blocked_next = 1'b0;

    pop_next = (st == STREAM) && (st_next == STREAM) && enable && !empty_fifo &&
               !blocked_next &&
               ((int'(occ_next) + int'(in_flight_next)) < SKID_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      pop        <= 1'b0;
      pop_sr     <= '0;
      in_flight  <= 2'd0;
      blocked    <= 1'b0;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      words_read <= 16'd0;
    end else begin
      st        <= st_next;
      pop       <= pop_next;
      pop_sr    <= (pop_sr << 1) | RD_LATENCY'(pop);
      in_flight <= in_flight_next;
      blocked   <= blocked_next;
      occ       <= occ_next;
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (transfer) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        words_read <= words_read + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && capture) buf_mem[wr_ptr] <= fifo_data_in;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a FIFO model with read latency feeds the DUT,
// a scoreboard queue holds the words loaded and checks them as they leave.
module tb_fifo_reader;
  localparam int DW = 10;
  localparam int RL = 2;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          error_fifo = 1'b0;
  logic          out_ready = 1'b0;
  logic          empty_fifo, almost_empty_fifo;
  logic [DW-1:0] fifo_data_in, out_data;
  logic          pop, out_valid, error_out;
  logic [1:0]    state, in_flight;
  logic [15:0]   words_read;

  int vectors = 0;
  int miscompares = 0;
  int fifo_wr = 0;
  int fifo_rd = 0;
  int ovr = 0;
  int pops = 0;
  int p0;
  logic [DW-1:0] pipe [RL];
  logic [DW-1:0] sb [$];

  fifo_reader #(.DATA_WIDTH(DW), .RD_LATENCY(RL), .SKID_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty_fifo(empty_fifo),
    .almost_empty_fifo(almost_empty_fifo), .error_fifo(error_fifo),
    .fifo_data_in(fifo_data_in), .pop(pop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .state(state),
    .in_flight(in_flight), .words_read(words_read), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // FIFO model: word index i carries value i+1; data appears RL cycles after pop.
  assign empty_fifo        = (fifo_wr == fifo_rd);
  assign almost_empty_fifo = ((fifo_wr - fifo_rd) == 1);
  assign fifo_data_in      = pipe[RL-1];

  always @(posedge clk) begin
    if (pop) begin
      if (fifo_wr == fifo_rd) ovr <= ovr + 1;
      else fifo_rd <= fifo_rd + 1;
      pipe[0] <= DW'(fifo_rd + 1);
    end else begin
      pipe[0] <= '0;
    end
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (pop) pops++;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(DW'(fifo_wr + 1));
      fifo_wr++;
    end
  endtask

  task automatic flush();
    sb.delete();
    fifo_wr = fifo_rd;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_pop", 32'(pop), 0);
    check("rst_state", 32'(state), 0);
    check("rst_in_flight", 32'(in_flight), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_words", 32'(words_read), 0);
    check("rst_err", 32'(error_out), 0);

    // five words streamed straight through
    load(5);
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    p0 = pops;
    repeat (30) tick();
    check("t1_words", 32'(words_read), 5);
    check("t1_state", 32'(state), 1);
    check("t1_sb_empty", 32'(sb.size()), 0);
    check("t1_pops", 32'(pops - p0), 5);
    check("t1_overread", 32'(ovr), 0);

    // back-pressure: buffer fills to SD words then pops stop
    out_ready = 1'b0;
    load(10);
    p0 = pops;
    repeat (12) tick();
    check("t2_pops", 32'(pops - p0), SD);
    check("t2_valid", 32'(out_valid), 1);
    check("t2_in_flight", 32'(in_flight), 0);
    check("t2_pop_low", 32'(pop), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    repeat (5) tick();
    check("t2_sb_empty", 32'(sb.size()), 0);
    check("t2_words", 32'(words_read), 15);
    check("t2_overread", 32'(ovr), 0);

    // single-word FIFO: pop, then blocked until the read lands
    load(1);
    for (int i = 0; i < 20 && pop !== 1'b1; i++) tick();
    check("t3_pop_seen", 32'(pop), 1);
    tick();
    load(3);
    check("t3_blk1", 32'(pop), 0);
    check("t3_blk1_if", 32'(in_flight), 1);
    tick();
    check("t3_blk2", 32'(pop), 0);
    check("t3_blk2_if", 32'(in_flight), 1);
    for (int i = 0; i < 5 && pop !== 1'b1; i++) tick();
    check("t3_unblock", 32'(pop), 1);
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    repeat (4) tick();
    check("t3_sb_empty", 32'(sb.size()), 0);
    check("t3_words", 32'(words_read), 19);
    check("t3_overread", 32'(ovr), 0);

    // drop enable with reads outstanding
    repeat (2) tick();
    load(6);
    for (int i = 0; i < 20 && in_flight != 2'd2; i++) tick();
    check("t4_in_flight", 32'(in_flight), 2);
    enable = 1'b0;
    tick();
    check("t4_drain", 32'(state), 2);
    for (int i = 0; i < 50 && state != 2'd0; i++) tick();
    check("t4_idle", 32'(state), 0);
    check("t4_sb_left", 32'(sb.size()), 32'(fifo_wr - fifo_rd));
    check("t4_valid", 32'(out_valid), 0);
    check("t4_overread", 32'(ovr), 0);

    // error while words sit in the buffer
    enable = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    repeat (4) tick();
    check("t5_sb_empty", 32'(sb.size()), 0);
    check("t5_in_flight", 32'(in_flight), 0);
    out_ready = 1'b0;
    load(3);
    repeat (10) tick();
    check("t5_buffered", 32'(out_valid), 1);
    error_fifo = 1'b1;
    tick();
    error_fifo = 1'b0;
    check("t5_state_err", 32'(state), 3);
    check("t5_error_out", 32'(error_out), 1);
    check("t5_pop_err", 32'(pop), 0);
    load(2);
    out_ready = 1'b1;
    p0 = pops;
    repeat (12) tick();
    check("t5_no_pops", 32'(pops - p0), 0);
    check("t5_sb_left", 32'(sb.size()), 2);
    check("t5_state_hold", 32'(state), 3);
    enable = 1'b0;
    repeat (3) tick();
    check("t5_sticky", 32'(state), 3);
    check("t5_valid", 32'(out_valid), 0);
    reset = 1'b0;
    repeat (2) tick();
    check("t5_rst_state", 32'(state), 0);
    check("t5_rst_err", 32'(error_out), 0);
    flush();
    reset = 1'b1;

    // words_read wrap
    enable = 1'b1; out_ready = 1'b1;
    load(65535);
    for (int i = 0; i < 70000 && words_read != 16'hFFFF; i++) tick();
    check("t6_words_max", 32'(words_read), 32'h0000_FFFF);
    check("t6_sb_empty", 32'(sb.size()), 0);
    load(1);
    for (int i = 0; i < 20 && words_read == 16'hFFFF; i++) tick();
    check("t6_words_wrap", 32'(words_read), 0);

    // reset with reads outstanding; late data must not be captured
    repeat (4) tick();
    load(10);
    for (int i = 0; i < 20 && in_flight != 2'd2; i++) tick();
    check("t6_in_flight", 32'(in_flight), 2);
    reset = 1'b0; enable = 1'b0;
    repeat (2) tick();
    flush();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_post_rst_valid", 32'(out_valid), 0);
    end
    check("t6_post_rst_if", 32'(in_flight), 0);
    check("t6_post_rst_state", 32'(state), 0);
    check("t6_post_rst_err", 32'(error_out), 0);
    check("t6_post_rst_words", 32'(words_read), 0);
    check("final_overread", 32'(ovr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, width of FIFO and output data.
REQ-002 SHALL have parameter RD_LATENCY, default 2, cycles from pop high to matching fifo_data_in valid; legal 1..3.
REQ-003 SHALL have parameter SKID_DEPTH, default 4, output buffer entries; SHALL be >= RD_LATENCY+1.
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  permits new pops when high.
REQ-007 SHALL have port empty_fifo  input  1  FIFO empty flag.
REQ-008 SHALL have port almost_empty_fifo  input  1  FIFO holds exactly one word.
REQ-009 SHALL have port error_fifo  input  1  FIFO error flag.
REQ-010 SHALL have port fifo_data_in  input  DATA_WIDTH  FIFO read data.
REQ-011 SHALL have port pop  output  1  read request to FIFO, registered.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  head of skid buffer.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.
REQ-015 SHALL have port state  output  2  IDLE=00, STREAM=01, DRAIN=10, ERROR=11.
REQ-016 SHALL have port in_flight  output  2  pops issued, data not yet captured.
REQ-017 SHALL have port words_read  output  16  count of output transfers.
REQ-018 SHALL have port error_out  output  1  high iff state==ERROR.

Function
REQ-019 SHALL track each pop in a RD_LATENCY-deep shift register; fifo_data_in SHALL be written into the skid buffer exactly RD_LATENCY cycles after the cycle pop was high.
REQ-020 Output transfer SHALL occur when out_valid and out_ready both high; head entry removed same edge.
REQ-021 out_valid SHALL be 1 iff skid buffer non-empty; out_data SHALL equal head entry, in FIFO order.
REQ-022 Skid buffer SHALL be circular, pointers wrap at SKID_DEPTH; simultaneous capture and transfer SHALL leave occupancy unchanged.
REQ-023 pop SHALL be asserted for next cycle only when: state==STREAM, enable==1, empty_fifo==0, occupancy+in_flight < SKID_DEPTH, and no pop is blocked per REQ-024.
REQ-024 After a pop issued while almost_empty_fifo==1, further pops SHALL be blocked until in_flight==0.
REQ-025 At most one pop per cycle; consecutive-cycle pops allowed when almost_empty_fifo==0.
REQ-026 in_flight SHALL increment on pop, decrement on capture, hold on both or neither.
REQ-027 words_read SHALL increment by 1 per output transfer, wrapping 0xFFFF->0x0000.
REQ-028 IDLE -> STREAM when enable==1.
REQ-029 STREAM -> DRAIN when enable==0; no new pops in DRAIN.
REQ-030 DRAIN -> STREAM when enable==1; DRAIN -> IDLE when enable==0, in_flight==0 and buffer empty.
REQ-031 Any state -> ERROR when error_fifo==1, or when a capture is due while in_flight==0 (internal inconsistency).
REQ-032 In ERROR pop SHALL be 0, captures SHALL be ignored, buffered words SHALL remain deliverable; ERROR SHALL be left only by reset.

Reset
REQ-033 While reset==0 at posedge: pop=0, state=IDLE, in_flight=0, buffer empty, out_valid=0, out_data=0, words_read=0, error_out=0, pop-tracking shift register cleared.
REQ-034 Reset mid-operation SHALL discard in-flight reads and buffered data; data returning after reset release SHALL NOT be captured.

Verification
REQ-035 FIFO holds 5 words 0x001..0x005, enable=1, out_ready=1 -> out_data 0x001..0x005 in order, words_read=5, state ends STREAM, no pop after empty_fifo=1.
REQ-036 out_ready=0, FIFO holds 10 words -> pops stop with occupancy+in_flight=4, out_valid=1 held; release out_ready -> all 10 words delivered without loss or duplicate.
REQ-037 FIFO holds 1 word (almost_empty_fifo=1) -> exactly one pop, then pop=0 until in_flight=0.
REQ-038 enable dropped with in_flight=2 -> DRAIN, both words delivered, then IDLE.
REQ-039 error_fifo=1 for one cycle in STREAM -> state=ERROR, error_out=1, pop=0 thereafter; only reset returns to IDLE.
REQ-040 Preload words_read=0xFFFF via 65535 transfers, one more transfer -> words_read=0x0000; reset with in_flight=2 -> out_valid stays 0 after release.
